mm_wb_buffer: RTL

Write-back collector for the matrix-multiply datapath, the writer-side counterpart of the LSU read buffer that skews RAM rows into the MXU. It captures the diagonally skewed per-lane result stream leaving the 16-lane systolic MXU and de-skews it into whole 128-bit rows. It writes each completed row to the local RAM with a byte strobe and flags completion to the LSU control.

---
 rtl/mm_pkg.sv | 34 +++
 rtl/mm_dff.sv | 41 ++++
 rtl/mm_wb_row_ent.sv | 30 +++
 rtl/mm_wb_buffer.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared sizes, FSM encoding and helpers for the matrix-multiply write-back path.
package mm_pkg;

  localparam int MM_LANES  = 16;
  localparam int MM_ELEM_W = 8;
  localparam int MM_ROW_W  = 128;
  localparam int MM_RAM_AW = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } mm_wb_state_e;

  typedef struct packed {
    logic                 vld;
    logic [MM_RAM_AW-1:0] addr;
    logic [MM_ROW_W-1:0]  data;
    logic [MM_LANES-1:0]  strb;
    logic                 done;
  } mm_wb_out_t;

  // Byte enables for columns 0..len inclusive.
  function automatic logic [MM_LANES-1:0] mm_strb_from_len(input logic [3:0] len);
    logic [MM_LANES-1:0] m;
    m = {MM_LANES{1'b0}};
    for (int i = 0; i < MM_LANES; i++) begin
      m[i] = (i <= int'(len));
    end
    return m;
  endfunction

endpackage

// File: rtl/mm_dff.sv
// Common resettable flop primitives: plain (DFFR) and load-enabled (DFFRE).
module mm_dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= {W{1'b0}};
    end else begin
      q_o <= d_i;
    end
  end

endmodule

module mm_dffre #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= {W{1'b0}};
    end else if (en_i) begin
      q_o <= d_i;
    end else begin
      q_o <= q_o;
    end
  end

endmodule

// File: rtl/mm_wb_row_ent.sv
// One de-skew row entry: 16 byte registers, cleared at job start, written one column at a time.
module mm_wb_row_ent
  import mm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 cap_i,
  input  logic [3:0]           col_i,
  input  logic [MM_ELEM_W-1:0] byte_i,
  output logic [MM_ROW_W-1:0]  row_nxt_o
);

  logic [MM_ROW_W-1:0] row_q;
  logic [MM_ROW_W-1:0] row_d;

  // Next row value is exported so the writer can bypass the final column's capture.
  always_comb begin
    row_d = row_q;
    for (int c = 0; c < MM_LANES; c++) begin
      row_d[c*MM_ELEM_W +: MM_ELEM_W] = (cap_i && (col_i == 4'(c))) ? byte_i :
                                        (clr_i ? {MM_ELEM_W{1'b0}} : row_q[c*MM_ELEM_W +: MM_ELEM_W]);
    end
  end

  mm_dffr #(.W(MM_ROW_W)) u_row (.clk(clk), .rst_n(rst_n), .d_i(row_d), .q_o(row_q));

  assign row_nxt_o = row_d;

endmodule

// File: rtl/mm_wb_buffer.sv
// Write-back collector: de-skews the per-lane MXU result stream into whole rows and
// writes each completed row to the local RAM, flagging the last one as done.
module mm_wb_buffer
  import mm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lsu_mm_wb_ctrl_vld,
  input  logic [3:0]           lsu_mm_wb_ctrl_row_len,
  input  logic [3:0]           lsu_mm_wb_ctrl_col_len,
  input  logic [11:0]          lsu_mm_wb_ctrl_start_addr,
  input  logic [MM_LANES-1:0]  mxu_lsu_mm_wb_vld,
  input  logic [MM_ROW_W-1:0]  mxu_lsu_mm_wb_data,
  output logic                 lsu_mm_wb_ram_write_vld,
  output logic [MM_RAM_AW-1:0] lsu_mm_wb_ram_write_addr,
  output logic [MM_ROW_W-1:0]  lsu_mm_wb_ram_write_data,
  output logic [MM_LANES-1:0]  lsu_mm_wb_ram_write_strb,
  output logic                 lsu_mm_wb_done
);

  logic                 vld_q;
  logic [1:0]           state_raw_q;
  mm_wb_state_e         state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [3:0]           row_len_q, col_len_q;
  logic [MM_RAM_AW-1:0] base_q;
  mm_wb_out_t           out_q, out_d;

  logic                 rise_s, start_s, active_s, wr_s, last_s;
  logic [3:0]           eff_row_s, eff_col_s;
  logic [MM_RAM_AW-1:0] eff_base_s;
  logic [5:0]           t_s, wr_row_s, lim_s;
  logic [MM_LANES-1:0]  cap_s;
  logic [3:0]           col_s [MM_LANES];
  logic [MM_ROW_W-1:0]  row_nxt_s [MM_LANES];
  logic                 unused_addr_s;

  assign unused_addr_s = ^lsu_mm_wb_ctrl_start_addr[3:0];
  assign state_q       = mm_wb_state_e'(state_raw_q);

  mm_dffr  #(.W(1))  u_vld   (.clk(clk), .rst_n(rst_n), .d_i(lsu_mm_wb_ctrl_vld), .q_o(vld_q));
  mm_dffr  #(.W(2))  u_state (.clk(clk), .rst_n(rst_n), .d_i(state_d), .q_o(state_raw_q));
  mm_dffr  #(.W(6))  u_cnt   (.clk(clk), .rst_n(rst_n), .d_i(cnt_d), .q_o(cnt_q));
  mm_dffre #(.W(16)) u_cfg   (.clk(clk), .rst_n(rst_n), .en_i(start_s),
                              .d_i({lsu_mm_wb_ctrl_row_len, lsu_mm_wb_ctrl_col_len,
                                    lsu_mm_wb_ctrl_start_addr[11:4]}),
                              .q_o({row_len_q, col_len_q, base_q}));
  mm_dffr  #(.W($bits(mm_wb_out_t))) u_out (.clk(clk), .rst_n(rst_n), .d_i(out_d), .q_o(out_q));

  // Job timing: the start cycle uses the live config so IDLE can fall through WAIT.
  always_comb begin
    rise_s     = lsu_mm_wb_ctrl_vld && !vld_q;
    start_s    = (state_q == ST_IDLE) && rise_s;
    eff_row_s  = start_s ? lsu_mm_wb_ctrl_row_len : row_len_q;
    eff_col_s  = start_s ? lsu_mm_wb_ctrl_col_len : col_len_q;
    eff_base_s = start_s ? lsu_mm_wb_ctrl_start_addr[11:4] : base_q;
    active_s   = lsu_mm_wb_ctrl_vld &&
                 ((state_q == ST_COLLECT) ||
                  (((state_q == ST_WAIT) || start_s) && mxu_lsu_mm_wb_vld[0]));
    t_s        = (state_q == ST_COLLECT) ? cnt_q : 6'd0;
    lim_s      = {2'b00, eff_row_s} + {2'b00, eff_col_s} + 6'd1;
    wr_row_s   = t_s - {2'b00, eff_col_s};
    wr_s       = active_s && (t_s >= {2'b00, eff_col_s}) && (wr_row_s <= {2'b00, eff_row_s});
    last_s     = wr_s && (wr_row_s[3:0] == eff_row_s);
  end

  // Lane r only contributes inside its diagonal window r..r+col_len.
  for (genvar g = 0; g < MM_LANES; g++) begin : g_lane
    localparam logic [5:0] LANE = 6'(g);
    logic [5:0] diff_s;
    assign diff_s   = t_s - LANE;
    assign cap_s[g] = active_s && mxu_lsu_mm_wb_vld[g] && (LANE <= {2'b00, eff_row_s}) &&
                      (t_s >= LANE) && (diff_s <= {2'b00, eff_col_s});
    assign col_s[g] = diff_s[3:0];

    mm_wb_row_ent u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (start_s),
      .cap_i    (cap_s[g]),
      .col_i    (col_s[g]),
      .byte_i   (mxu_lsu_mm_wb_data[g*MM_ELEM_W +: MM_ELEM_W]),
      .row_nxt_o(row_nxt_s[g])
    );
  end

  // Next state and cycle counter; dropping ctrl_vld mid-job returns straight to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = 6'd0;
    if (active_s) begin
      state_d = last_s ? ST_DONE : ST_COLLECT;
      cnt_d   = (t_s >= lim_s) ? lim_s : (t_s + 6'd1);
    end else begin
      case (state_q)
        ST_IDLE:    state_d = rise_s ? ST_WAIT : ST_IDLE;
        ST_WAIT:    state_d = lsu_mm_wb_ctrl_vld ? ST_WAIT : ST_IDLE;
        ST_COLLECT: state_d = ST_IDLE;
        ST_DONE:    state_d = lsu_mm_wb_ctrl_vld ? ST_DONE : ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Registered RAM write; data comes from the entry's next value to keep 1-cycle latency.
  always_comb begin
    out_d      = '{default: '0};
    out_d.vld  = wr_s;
    out_d.done = last_s;
    if (wr_s) begin
      out_d.addr = eff_base_s + {4'h0, wr_row_s[3:0]};
      out_d.data = row_nxt_s[wr_row_s[3:0]];
      out_d.strb = mm_strb_from_len(eff_col_s);
    end else begin
      out_d.addr = {MM_RAM_AW{1'b0}};
      out_d.data = {MM_ROW_W{1'b0}};
      out_d.strb = {MM_LANES{1'b0}};
    end
  end

  assign lsu_mm_wb_ram_write_vld  = out_q.vld;
  assign lsu_mm_wb_ram_write_addr = out_q.addr;
  assign lsu_mm_wb_ram_write_data = out_q.data;
  assign lsu_mm_wb_ram_write_strb = out_q.strb;
  assign lsu_mm_wb_done           = out_q.done;

endmodule
